// File: rtl/io_sync_debounce_pkg.sv
// rtl/io_sync_debounce_pkg.sv - shared types, limits and width helpers for io_sync_debounce
// Purpose : debounce state encoding, legal parameter ranges and counter width helpers
//           used by io_sync_debounce and io_sync_channel.
// Ports   : none (package).
package io_sync_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } debState_t;

  localparam int CHANNELS_MIN    = 1;
  localparam int CHANNELS_MAX    = 16;
  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;
  localparam int DEBOUNCE_MIN    = 2;
  localparam int DEBOUNCE_MAX    = 65535;

  // Debounce counter only ever needs to hold 0..DEBOUNCE_CYCLES-1.
  function automatic int debWidth(input int cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

  // Hold counter saturates at LONG_CYCLES, so it must represent that value itself.
  function automatic int holdWidth(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/io_sync_debounce_if.sv
// rtl/io_sync_debounce_if.sv - pad-to-core conditioning bus for io_sync_debounce
// Purpose : bundles the raw pad inputs and the conditioned per-channel outputs.
// Ports   : RawIn   - unsynchronised pad inputs (driven by master)
//           Level   - debounced, polarity-normalised level (driven by slave)
//           Press   - one-cycle pulse on Level rising
//           Release - one-cycle pulse on Level falling
//           Hold    - one-cycle long-press pulse
// Modports: master = pad/core side, slave = io_sync_debounce.
interface io_sync_debounce_if #(
  parameter int CHANNELS = 4
);

  logic [CHANNELS-1:0] RawIn;
  logic [CHANNELS-1:0] Level;
  logic [CHANNELS-1:0] Press;
  logic [CHANNELS-1:0] Release;
  logic [CHANNELS-1:0] Hold;

  modport master (
    output RawIn,
    input  Level,
    input  Press,
    input  Release,
    input  Hold
  );

  modport slave (
    input  RawIn,
    output Level,
    output Press,
    output Release,
    output Hold
  );

endinterface

// File: rtl/io_sync_debounce_channel.sv
// rtl/io_sync_debounce_channel.sv - one input channel: sync chain, debounce FSM, hold counter
// Purpose : conditions a single pad input into a clean level plus press/release/hold pulses.
// Ports   : Clock        - system clock, rising edge
//           Reset        - asynchronous, active-high
//           raw          - unsynchronised pad input
//           level        - debounced level, 1 = asserted
//           pressPulse   - one cycle, first cycle of level=1
//           releasePulse - one cycle, first cycle of level=0
//           holdPulse    - one cycle, LONG_CYCLES cycles after pressPulse
// Build   : IO_SYNC_DEBOUNCE_EN defined builds the debounce FSM; undefined gives a
//           plain registered level with edge-detect pulses.
module io_sync_channel
  import io_sync_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int LONG_CYCLES     = 1024,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic Clock,
  input  logic Reset,
  input  logic raw,
  output logic level,
  output logic pressPulse,
  output logic releasePulse,
  output logic holdPulse
);

  if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : gBadSync
    $error("io_sync_channel: SYNC_STAGES out of range");
  end
  if (DEBOUNCE_CYCLES < DEBOUNCE_MIN || DEBOUNCE_CYCLES > DEBOUNCE_MAX) begin : gBadDebounce
    $error("io_sync_channel: DEBOUNCE_CYCLES out of range");
  end
  if (LONG_CYCLES <= DEBOUNCE_CYCLES) begin : gBadLong
    $error("io_sync_channel: LONG_CYCLES must exceed DEBOUNCE_CYCLES");
  end

  // ---------------------------------------------------------------------------
  // Synchroniser chain. Resets to the inactive raw level so a released button
  // does not look like an edge when reset drops.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] syncQ;
  logic                   s;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      syncQ <= {SYNC_STAGES{ACTIVE_LOW}};
    end else begin
      syncQ <= {syncQ[SYNC_STAGES-2:0], raw};
    end
  end

  assign s = syncQ[SYNC_STAGES-1] ^ ACTIVE_LOW;

`ifdef IO_SYNC_DEBOUNCE_EN
  // ---------------------------------------------------------------------------
  // Debounce FSM. The first differing sample moves to a WAIT state with the
  // counter at 0; each further differing sample increments it, and the sample
  // that brings it to DEBOUNCE_CYCLES-1 commits the new level. That makes
  // exactly DEBOUNCE_CYCLES consecutive differing samples per level change.
  // ---------------------------------------------------------------------------
  localparam int            DW       = debWidth(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 2);

  debState_t     state, stateNext;
  logic [DW-1:0] debCnt, debCntNext;
  logic          pressNext, releaseNext;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state        <= STABLE_LO;
      debCnt       <= '0;
      pressPulse   <= 1'b0;
      releasePulse <= 1'b0;
    end else begin
      state        <= stateNext;
      debCnt       <= debCntNext;
      pressPulse   <= pressNext;
      releasePulse <= releaseNext;
    end
  end

  always_comb begin
    stateNext   = state;
    debCntNext  = debCnt;
    pressNext   = 1'b0;
    releaseNext = 1'b0;
    unique case (state)
      STABLE_LO: begin
        if (s) begin
          stateNext  = WAIT_HI;
          debCntNext = '0;
        end
      end
      WAIT_HI: begin
        if (!s) begin
          stateNext = STABLE_LO;
        end else begin
          debCntNext = debCnt + 1'b1;
          if (debCnt == DEB_LAST) begin
            stateNext = STABLE_HI;
            pressNext = 1'b1;
          end
        end
      end
      STABLE_HI: begin
        if (!s) begin
          stateNext  = WAIT_LO;
          debCntNext = '0;
        end
      end
      WAIT_LO: begin
        if (s) begin
          stateNext = STABLE_HI;
        end else begin
          debCntNext = debCnt + 1'b1;
          if (debCnt == DEB_LAST) begin
            stateNext   = STABLE_LO;
            releaseNext = 1'b1;
          end
        end
      end
      default: stateNext = STABLE_LO;
    endcase
  end

  // Level stays high while a release is still being qualified.
  assign level = (state == STABLE_HI) || (state == WAIT_LO);
`else
  // ---------------------------------------------------------------------------
  // No debounce: one register after the sync chain, pulses are edge detects
  // computed from the same sample so they line up with the level change.
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      level        <= 1'b0;
      pressPulse   <= 1'b0;
      releasePulse <= 1'b0;
    end else begin
      level        <= s;
      pressPulse   <= s & ~level;
      releasePulse <= ~s & level;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Hold counter. Reads 0 on the press cycle and counts every cycle level is
  // high; the pulse is registered from the cycle it reads LONG_CYCLES-1, so it
  // lands LONG_CYCLES cycles after the press. Saturating at LONG_CYCLES keeps
  // it from firing twice in one press.
  // ---------------------------------------------------------------------------
  localparam int            HW        = holdWidth(LONG_CYCLES);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);
  localparam logic [HW-1:0] HOLD_FIRE = HW'(LONG_CYCLES - 1);

  logic [HW-1:0] holdCnt;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      holdCnt   <= '0;
      holdPulse <= 1'b0;
    end else begin
      if (!level) begin
        holdCnt <= '0;
      end else if (holdCnt != HOLD_MAX) begin
        holdCnt <= holdCnt + 1'b1;
      end
      holdPulse <= level && (holdCnt == HOLD_FIRE);
    end
  end

endmodule

// File: rtl/io_sync_debounce.sv
// rtl/io_sync_debounce.sv - N-channel pad input synchroniser and debouncer
// Purpose : replaces ad hoc two-flop synchronisers for button/sensor inputs; each
//           channel yields a clean level and press/release/long-press pulses.
// Ports   : Clock - system clock, rising edge
//           Reset - asynchronous, active-high
//           bus   - io_sync_debounce_if.slave: RawIn in; Level, Press, Release, Hold out
// Build   : IO_SYNC_DEBOUNCE_EN defined enables the debounce FSM in every channel;
//           undefined gives synchronise-and-register only (DEBOUNCE_CYCLES ignored).
module io_sync_debounce
  import io_sync_pkg::*;
#(
  parameter int CHANNELS        = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int LONG_CYCLES     = 1024,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic                Clock,
  input  logic                Reset,
  io_sync_debounce_if.slave   bus
);

  if (CHANNELS < CHANNELS_MIN || CHANNELS > CHANNELS_MAX) begin : gBadChannels
    $error("io_sync_debounce: CHANNELS out of range");
  end

  logic [CHANNELS-1:0] levelVec;
  logic [CHANNELS-1:0] pressVec;
  logic [CHANNELS-1:0] releaseVec;
  logic [CHANNELS-1:0] holdVec;

  for (genvar i = 0; i < CHANNELS; i++) begin : gChan
    io_sync_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES    (LONG_CYCLES),
      .ACTIVE_LOW     (ACTIVE_LOW)
    ) uChan (
      .Clock       (Clock),
      .Reset       (Reset),
      .raw         (bus.RawIn[i]),
      .level       (levelVec[i]),
      .pressPulse  (pressVec[i]),
      .releasePulse(releaseVec[i]),
      .holdPulse   (holdVec[i])
    );
  end

  assign bus.Level   = levelVec;
  assign bus.Press   = pressVec;
  assign bus.Release = releaseVec;
  assign bus.Hold    = holdVec;

endmodule

// File: tb/tb_io_sync_debounce.sv
// tb/tb_io_sync_debounce.sv - self-checking bench for io_sync_debounce
module tb_io_sync_debounce;

  localparam int CH   = 4;
  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int LONG = 20;
  localparam bit AL   = 1'b1;
`ifdef IO_SYNC_DEBOUNCE_EN
  localparam bit DEB_ON = 1'b1;
`else
  localparam bit DEB_ON = 1'b0;
`endif
  localparam int LATENCY = DEB_ON ? (SYNC + DEB) : (SYNC + 1);

  logic Clock = 1'b0;
  logic Reset = 1'b1;

  io_sync_debounce_if #(.CHANNELS(CH)) bus ();

  io_sync_debounce #(
    .CHANNELS       (CH),
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB),
    .LONG_CYCLES    (LONG),
    .ACTIVE_LOW     (AL)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .bus  (bus)
  );

  always #5 Clock = ~Clock;

  int testsRun = 0;
  int testsFailed = 0;

  // Reference model: per-channel sample delay line, run length of samples that
  // disagree with the level, and length of the current high stretch.
  bit          mQ[CH][$];
  int          mRun[CH];
  int          mHigh[CH];
  logic [CH-1:0] mLevel, mPress, mRelease, mHold;

  int cyc = 0;
  int markCyc = 0;
  int pressCnt[CH], releaseCnt[CH], holdCnt[CH];
  int firstPress[CH], firstRelease[CH], firstHold[CH];
  bit sawBoth = 1'b0;

  task automatic modelReset();
    for (int c = 0; c < CH; c++) begin
      mQ[c].delete();
      for (int k = 0; k < SYNC; k++) mQ[c].push_back(1'b0);
      mRun[c]  = 0;
      mHigh[c] = 0;
    end
    mLevel = '0; mPress = '0; mRelease = '0; mHold = '0;
  endtask

  task automatic modelEdge(input logic [CH-1:0] raw);
    bit sv, prev, nl;
    for (int c = 0; c < CH; c++) begin
      sv = mQ[c].pop_front();
      mQ[c].push_back(raw[c] ^ AL);
      prev = mLevel[c];
      nl = prev;
      if (DEB_ON) begin
        if (sv != prev) mRun[c]++; else mRun[c] = 0;
        if (mRun[c] == DEB) begin
          nl = sv;
          mRun[c] = 0;
        end
      end else begin
        nl = sv;
      end
      mHold[c]    = prev && (mHigh[c] == LONG);
      mHigh[c]    = nl ? ((mHigh[c] < 100000) ? mHigh[c] + 1 : mHigh[c]) : 0;
      mPress[c]   = nl & ~prev;
      mRelease[c] = ~nl & prev;
      mLevel[c]   = nl;
    end
  endtask

  task automatic checkOutputs(input string tag);
    testsRun++;
    assert (bus.Level === mLevel) else begin
      testsFailed++;
      $error("FAIL %s@%0d Level observed=%b expected=%b", tag, cyc, bus.Level, mLevel);
    end
    testsRun++;
    assert (bus.Press === mPress) else begin
      testsFailed++;
      $error("FAIL %s@%0d Press observed=%b expected=%b", tag, cyc, bus.Press, mPress);
    end
    testsRun++;
    assert (bus.Release === mRelease) else begin
      testsFailed++;
      $error("FAIL %s@%0d Release observed=%b expected=%b", tag, cyc, bus.Release, mRelease);
    end
    testsRun++;
    assert (bus.Hold === mHold) else begin
      testsFailed++;
      $error("FAIL %s@%0d Hold observed=%b expected=%b", tag, cyc, bus.Hold, mHold);
    end
  endtask

  task automatic expectInt(input string tag, input int obs, input int exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clearCounts();
    markCyc = cyc;
    sawBoth = 1'b0;
    for (int c = 0; c < CH; c++) begin
      pressCnt[c] = 0; releaseCnt[c] = 0; holdCnt[c] = 0;
      firstPress[c] = -1; firstRelease[c] = -1; firstHold[c] = -1;
    end
  endtask

  task automatic step(input logic [CH-1:0] raw);
    bus.RawIn = raw;
    @(posedge Clock);
    modelEdge(raw);
    cyc++;
    #1;
    checkOutputs("cycle");
    for (int c = 0; c < CH; c++) begin
      if (bus.Press[c] === 1'b1) begin
        pressCnt[c]++;
        if (firstPress[c] < 0) firstPress[c] = cyc - markCyc;
      end
      if (bus.Release[c] === 1'b1) begin
        releaseCnt[c]++;
        if (firstRelease[c] < 0) firstRelease[c] = cyc - markCyc;
      end
      if (bus.Hold[c] === 1'b1) begin
        holdCnt[c]++;
        if (firstHold[c] < 0) firstHold[c] = cyc - markCyc;
      end
    end
    if (bus.Press === 4'b0101) sawBoth = 1'b1;
  endtask

  task automatic steps(input logic [CH-1:0] raw, input int n);
    for (int i = 0; i < n; i++) step(raw);
  endtask

  // Reset is raised mid-cycle so its asynchronous effect is observed before any edge.
  task automatic doReset(input logic [CH-1:0] raw);
    #2;
    Reset = 1'b1;
    bus.RawIn = raw;
    #1;
    modelReset();
    checkOutputs("asyncReset");
    @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
  endtask

  logic [CH-1:0] rawCur;
  int            rem[CH];

  initial begin
    bus.RawIn = 4'hF;
    modelReset();
    clearCounts();
    @(posedge Clock);
    @(posedge Clock);
    #1;
    checkOutputs("reset");
    expectInt("resetLevel", int'(bus.Level), 0);
    expectInt("resetPulses", int'(bus.Press | bus.Release | bus.Hold), 0);
    @(negedge Clock);
    Reset = 1'b0;
    steps(4'hF, 4);

    // Channel 0 press and release latency.
    clearCounts();
    steps(4'hE, 12);
    expectInt("ch0PressCount", pressCnt[0], 1);
    expectInt("ch0PressLatency", firstPress[0], LATENCY);
    expectInt("ch0LevelHigh", int'(bus.Level[0]), 1);
    clearCounts();
    steps(4'hF, 12);
    expectInt("ch0ReleaseCount", releaseCnt[0], 1);
    expectInt("ch0ReleaseLatency", firstRelease[0], LATENCY);

    // Channel 1 three-cycle glitch.
    clearCounts();
    steps(4'hD, 3);
    steps(4'hF, 12);
    expectInt("ch1GlitchPress", pressCnt[1], DEB_ON ? 0 : 1);
    expectInt("ch1GlitchRelease", releaseCnt[1], DEB_ON ? 0 : 1);

    // Channel 2 bouncing every 2 cycles, then held.
    clearCounts();
    for (int i = 0; i < 20; i++) step(((i / 2) % 2 == 1) ? 4'hF : 4'hB);
    steps(4'hB, 12);
    expectInt("ch2BouncePress", pressCnt[2], DEB_ON ? 1 : 6);
    steps(4'hF, 12);

    // Channel 3 long press.
    clearCounts();
    steps(4'h7, 40);
    steps(4'hF, 12);
    expectInt("ch3Press", pressCnt[3], 1);
    expectInt("ch3HoldCount", holdCnt[3], 1);
    expectInt("ch3HoldGap", firstHold[3] - firstPress[3], LONG);
    expectInt("ch3Release", releaseCnt[3], 1);

    // Channels 0 and 2 together, then reset while held.
    clearCounts();
    steps(4'hA, 10);
    expectInt("simulPress", int'(sawBoth), 1);
    doReset(4'hF);
    expectInt("resetLevelNow", int'(bus.Level), 0);
    clearCounts();
    steps(4'hF, 8);
    expectInt("noReleaseAfterReset", releaseCnt[0] + releaseCnt[2], 0);

    // Random run lengths per channel, with one reset in the middle.
    rawCur = 4'hF;
    for (int c = 0; c < CH; c++) rem[c] = 0;
    for (int t = 0; t < 600; t++) begin
      for (int c = 0; c < CH; c++) begin
        if (rem[c] == 0) begin
          rawCur[c] = 1'($urandom_range(0, 1));
          rem[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(5, 30))
                                              : int'($urandom_range(1, 5));
        end
        rem[c]--;
      end
      step(rawCur);
      if (t == 300) doReset(4'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
